// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: state encodings and slice width.
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Single 4-bit ripple-carry adder slice; the only arithmetic in the serial adder datapath.
module ripple_carry_adder_4bit
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds or subtracts WIDTH-bit operands one nibble per cycle (LSB first) through one 4-bit slice,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam int unsigned RES_W = WIDTH - SLICE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [RES_W-1:0]   res_q;
  logic [RES_W-1:0]   res_next;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;
  logic               ovf_next;

  assign sl_a = a_q[idx_q * SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx_q * SLICE_W +: SLICE_W];

  ripple_carry_adder_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Lower nibbles accumulate here; the top nibble goes straight to sum on the last step.
  always_comb begin
    res_next = res_q;
    for (int n = 0; n < int'(NIB) - 1; n++) begin
      if (idx_q == IDX_W'(n)) begin
        res_next[n * SLICE_W +: SLICE_W] = sl_sum;
      end
    end
  end

  assign ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[SLICE_W-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= sub | cin;
            idx_q    <= '0;
            state    <= StRun;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          res_q   <= res_next;
          carry_q <= sl_cout;
          if (idx_q == LAST_IDX) begin
            sum       <= {sl_sum, res_q};
            cout      <= sl_cout;
            ovf       <= ovf_next;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and random checks of the nibble-serial adder at WIDTH=16 and WIDTH=8.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, busy8;
  logic [7:0]   a8, b8, sum8;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .sub       (sub8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8),
    .busy      (busy8)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference built from integer arithmetic, independent of the nibble structure.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t        e;
    logic [W:0]  u;
    int          sr;
    if (msub) begin
      u      = {1'b0, ma} - {1'b0, mb};
      e.cout = (ma >= mb);
      sr     = int'($signed(ma)) - int'($signed(mb));
    end else begin
      u      = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      e.cout = u[W];
      sr     = int'($signed(ma)) + int'($signed(mb)) + int'({31'b0, mcin});
    end
    e.sum = u[W-1:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed unexpected result %0h expected none", tag, sum);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
      chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic ocin, input logic osub, output logic [W-1:0] got);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    sb.push_back(model(oa, ob, ocin, osub));
    tick();
    in_valid = 1'b0;
    chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    wait_valid(tag, 4);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    check_out(tag);
    got = sum;
    tick();
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run8(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                      input logic ocin, input logic osub,
                      input logic [7:0] es, input logic ec, input logic eo);
    int lat = 0;
    a8 = oa; b8 = ob; cin8 = ocin; sub8 = osub; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_cout"}, 32'(cout8), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    tick();
    chk({tag, "_out_valid_drop"}, 32'(out_valid8), 32'd0);
  endtask

  initial begin
    logic [W-1:0] got;
    exp_t         e1;
    int           seen;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Directed arithmetic cases.
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, got);
    chk("add_basic_const", 32'(got), 32'h5555);
    run_op("ripple_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, got);
    chk("ripple_ffff_const", 32'(got), 32'h0000);
    run_op("ripple_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, got);
    chk("ripple_cin_const", 32'(got), 32'h0010);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, got);
    chk("ovf_add_const", 32'(got), 32'h8000);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, got);
    chk("ovf_sub_const", 32'(got), 32'h7FFF);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, got);
    chk("sub_borrow_const", 32'(got), 32'hFFFE);

    // Backpressure: result held, second request ignored until back in idle.
    out_ready = 1'b0;
    a = 16'hA5A5; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    e1 = model(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    sb.push_back(e1);
    tick();
    in_valid = 1'b0;
    wait_valid("bp1", 4);
    check_out("bp1");
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100; b = 16'h0023; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum), 32'(e1.sum));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("bp_hold_sum_end", 32'(sum), 32'(e1.sum));
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    sb.push_back(model(16'h0100, 16'h0023, 1'b0, 1'b0));
    tick();
    in_valid = 1'b0;
    chk("bp2_in_ready", 32'(in_ready), 32'd0);
    chk("bp2_busy", 32'(busy), 32'd1);
    wait_valid("bp2", 4);
    check_out("bp2");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("bp2_accepted_once", 32'(seen), 32'd0);

    // Reset in the second RUN cycle discards the operation.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, got);
    chk("after_rst_const", 32'(got), 32'h0002);

    // Random operations against the integer model.
    for (int i = 0; i < 20; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), got);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Narrow instance: two-cycle latency.
    run8("w8_add", 8'h34, 8'h21, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    run8("w8_ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("w8_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    run8("w8_ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("w8_ovf_sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run8("w8_sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
